// File: rtl/regfile_mp_fwd.sv
// Multi-port GPR file with two write ports, write-to-read bypass and a
// per-register busy scoreboard for decode-stage stall detection.
module regfile_mp_fwd #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_addr,
    input  logic                     flush
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]  busy_reg;
    logic [DEPTH-1:0]  busy_next;

    logic wr0_act;
    logic wr1_act;

    assign wr0_act = we0 && (wa0 != '0);
    assign wr1_act = we1 && (wa1 != '0);

    // Port 1 is applied last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (wr0_act) begin
                mem_reg[wa0] <= wd0;
            end
            if (wr1_act) begin
                mem_reg[wa1] <= wd1;
            end
        end
    end

    // Retiring writes clear, a new issue sets (superseding), flush wipes all.
    always_comb begin
        busy_next = busy_reg;
        if (wr0_act) begin
            busy_next[wa0] = 1'b0;
        end
        if (wr1_act) begin
            busy_next[wa1] = 1'b0;
        end
        if (busy_set && (busy_addr != '0)) begin
            busy_next[busy_addr] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra_k;
            logic              hit1;
            logic              hit0;
            logic [DATA_W-1:0] rd_k;
            logic              rbusy_k;

            assign ra_k = ra[gi*ADDR_W +: ADDR_W];
            assign hit1 = we1 && (wa1 == ra_k);
            assign hit0 = we0 && (wa0 == ra_k);

            // Outputs are forced low while reset is held so in-flight bypass
            // data cannot leak out during reset.
            always_comb begin
                rd_k    = '0;
                rbusy_k = 1'b0;
                if (rst_n && re[gi] && (ra_k != '0)) begin
                    if (hit1) begin
                        rd_k = wd1;
                    end else if (hit0) begin
                        rd_k = wd0;
                    end else begin
                        rd_k = mem_reg[ra_k];
                    end
                    rbusy_k = busy_reg[ra_k] && !(hit1 || hit0);
                end
            end

            assign rd[gi*DATA_W +: DATA_W] = rd_k;
            assign rbusy[gi]               = rbusy_k;
        end
    endgenerate

endmodule
